uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set bits per frame.
REQ-003 Parameter BPS, default 115_200, SHALL set the serial bit rate.
REQ-004 Parameter SYS_CLK_FREQ, default 50_000_000, SHALL set the clk frequency in Hz.
REQ-005 Parameter PARITY, default 0, SHALL select parity: 0 none, 1 even, 2 odd.
REQ-006 Parameter STOP_BITS, default 1, SHALL select the number of stop bits; legal values are 1 and 2.
REQ-007 clk  input  1  system clock.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 tx_data  input  DATA_WIDTH  byte to transmit; sampled only on accept.
REQ-010 tx_en  input  1  request; accept = tx_en & tx_ready.
REQ-011 tx_ready  output  1  high when the holding register is empty.
REQ-012 tx_done  output  1  one-clk pulse at frame completion.
REQ-013 tx_busy  output  1  high while state != IDLE.
REQ-014 tx  output  1  serial line, idle high.

Function
REQ-015 CPB = SYS_CLK_FREQ/BPS (integer division) SHALL be the clk cycles per serial bit; CPB < 2 is illegal.
REQ-016 States SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-017 Baud counter: counts 0..CPB-1 in every non-IDLE state, clears on each state/bit advance, and is held at 0 in IDLE.
REQ-018 Accept in IDLE (hold empty): tx_data loads the shift register, FSM enters START next cycle; tx=0 from the cycle after accept (latency 1).
REQ-019 Accept in any non-IDLE state: tx_data loads the holding register; tx_ready drops the next cycle.
REQ-020 tx_en while tx_ready=0: ignored, holding register unchanged.
REQ-021 START: tx=0 for CPB cycles, then DATA.
REQ-022 DATA: DATA_WIDTH bits, LSB first, CPB cycles each; a bit index of width clog2(DATA_WIDTH) wraps to 0 on exit.
REQ-023 PARITY: tx = XOR of data bits (even) or its inverse (odd), for CPB cycles.
REQ-024 STOP: tx=1 for STOP_BITS*CPB cycles.
REQ-025 Frame end: tx_done=1 for exactly the one cycle following the final STOP cycle.
REQ-026 Frame end with hold full: the same edge moves hold to shift, clears hold, and enters START (tx=0 concurrent with tx_done, no idle gap); tx_ready rises next cycle.
REQ-027 Frame end with hold empty: enter IDLE; tx_busy=0 concurrent with tx_done.
REQ-028 IDLE with hold full (accept landed on the final STOP cycle): next edge moves hold to shift and enters START.
REQ-029 Data SHALL be latched at accept; tx_data changes after accept do not affect the frame.
REQ-030 tx SHALL be driven from a register (glitch-free).

Reset
REQ-031 With rst=1 at a clk edge, next cycle: FSM IDLE, counters 0, hold empty, tx=1, tx_ready=1, tx_busy=0, tx_done=0.
REQ-032 Reset mid-frame SHALL abort the frame without a tx_done pulse; the held byte is discarded.

Verification (bench: SYS_CLK_FREQ=8, BPS=1 -> CPB=8; cycle 0 = accept cycle)
REQ-033 Reset -> tx=1, tx_ready=1, tx_busy=0, tx_done=0 the cycle after release.
REQ-034 PARITY=0, STOP_BITS=1, send 0xA5 -> tx=0 cycles 1-8; bits 1,0,1,0,0,1,0,1 in 8-cycle slots cycles 9-72; tx=1 cycles 73-80; tx_done=1 only in cycle 81; tx_busy=0 from 81.
REQ-035 Send 0x01, then 0x80 at cycle 5 -> tx_ready=0 cycles 6-81; second start bit cycles 81-88; tx_done pulses at 81 and 161; tx_ready=1 from 82.
REQ-036 PARITY=1 send 0x07 -> parity slot (cycles 73-80) tx=1; PARITY=2 same byte -> tx=0; stop cycles 81-88; tx_done at 89.
REQ-037 Hold full, tx_en with 0x3C -> ignored; 0x3C never appears on tx.
REQ-038 STOP_BITS=2, 0xFF, rst asserted at cycle 40 -> tx=1 from cycle 41, no tx_done, tx_ready=1; a new 0x00 accepted later transmits a normal frame.

Source files
------------

// File: rtl/uart_tx_if.sv
// uart_tx_if: transmit-side handshake and serial line for uart_tx.
//   master: drives tx_data/tx_en; observes tx_ready, tx_done, tx_busy, tx.
//   slave : the transmitter itself.
//   tx_data    byte to send, sampled only on accept (tx_en & tx_ready)
//   tx_en      send request
//   tx_ready   holding register empty
//   tx_done    one-cycle pulse at frame completion
//   tx_busy    transmitter not idle
//   tx         serial line, idles high
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_en;
  logic                  tx_ready;
  logic                  tx_done;
  logic                  tx_busy;
  logic                  tx;

  modport master (output tx_data, tx_en, input tx_ready, tx_done, tx_busy, tx);
  modport slave  (input tx_data, tx_en, output tx_ready, tx_done, tx_busy, tx);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with a one-deep holding register.
//   Frame: start(0), DATA_WIDTH bits LSB first, optional parity, STOP_BITS stop(1).
//   Each bit lasts CPB = SYS_CLK_FREQ/BPS clocks (CPB >= 2 required).
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   uart_tx_if.slave (tx_data, tx_en, tx_ready, tx_done, tx_busy, tx)
// A byte accepted while idle goes straight to the shift register; a byte
// accepted mid-frame waits in the holding register and follows back-to-back.
module uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int BPS          = 115_200,
  parameter int SYS_CLK_FREQ = 50_000_000,
  parameter int PARITY       = 0,   // 0 none, 1 even, 2 odd
  parameter int STOP_BITS    = 1    // 1 or 2
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus
);
  localparam int CPB   = SYS_CLK_FREQ / BPS;
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CPB - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             ODD       = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  stop_q, stop_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  tx_q, tx_d;
  logic                  accept, cnt_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      stop_q      <= 1'b0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stop_q      <= stop_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      tx_q        <= tx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    idx_d       = idx_q;
    stop_d      = stop_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    done_d      = 1'b0;
    accept      = bus.tx_en & ready_q;
    cnt_last    = (cnt_q == CNT_LAST);

    if (state_q != S_IDLE) cnt_d = cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        // A held byte here means it landed on the last stop cycle.
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          state_d     = S_START;
        end else if (accept) begin
          shift_d = bus.tx_data;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_last) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            stop_d  = 1'b0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (cnt_last) begin
          cnt_d   = '0;
          stop_d  = 1'b0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (stop_q == STOP_LAST) begin
            done_d = 1'b1;
            stop_d = 1'b0;
            // Back-to-back: start bit goes out in the same cycle as tx_done.
            if (hold_full_q) begin
              shift_d     = hold_q;
              hold_full_d = 1'b0;
              state_d     = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Accept mid-frame parks the byte; ready_q guarantees the hold is empty.
    if (accept && (state_q != S_IDLE)) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end

    // Ready drops right after a park and rises one cycle after the hold drains.
    ready_d = ~(hold_full_q | hold_full_d);

    // Line level is computed for the next state so tx comes straight off a flop.
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[idx_d];
      S_PARITY: tx_d = (^shift_d) ^ ODD;
      default:  tx_d = 1'b1;
    endcase
  end

  assign bus.tx       = tx_q;
  assign bus.tx_ready = ready_q;
  assign bus.tx_done  = done_q;
  assign bus.tx_busy  = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three transmitters (none/1 stop, even/1 stop, odd/2 stop) with
// CPB = 8 share one stimulus stream. A frame-timeline model predicts every
// output each cycle from the list of accepted bytes and their start cycles.
module tb_uart_tx;
  localparam int DW   = 8;
  localparam int CPB  = 8;
  localparam int NDUT = 3;
  localparam int MAXF = 512;

  typedef struct {
    int            start;
    int            acc;
    bit            held;
    logic [DW-1:0] data;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_en = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic [NDUT-1:0] o_tx, o_busy, o_done, o_ready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  frame_t fr [NDUT][MAXF];
  int nfr [NDUT];

  always #5 clk = ~clk;

  uart_tx_if #(.DATA_WIDTH(DW)) bus [NDUT] ();

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    uart_tx #(
      .DATA_WIDTH(DW), .BPS(1), .SYS_CLK_FREQ(8),
      .PARITY(g), .STOP_BITS((g == 2) ? 2 : 1)
    ) dut (
      .clk(clk), .rst(rst), .bus(bus[g])
    );
    assign bus[g].tx_en   = tx_en;
    assign bus[g].tx_data = tx_data;
    assign o_tx[g]    = bus[g].tx;
    assign o_busy[g]  = bus[g].tx_busy;
    assign o_done[g]  = bus[g].tx_done;
    assign o_ready[g] = bus[g].tx_ready;
  end

  function automatic int stop_of(int k);
    return (k == 2) ? 2 : 1;
  endfunction

  function automatic int flen(int k);
    return (1 + DW + ((k != 0) ? 1 : 0) + stop_of(k)) * CPB;
  endfunction

  // Line level at offset off into a frame carrying d.
  function automatic logic line_at(int k, logic [DW-1:0] d, int off);
    int slot;
    slot = off / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= DW) return d[slot-1];
    if (k != 0 && slot == DW + 1) return (^d) ^ (k == 2);
    return 1'b1;
  endfunction

  // Not ready from the cycle after a parked accept through that frame's start.
  function automatic logic exp_ready(int k, int c);
    for (int i = 0; i < nfr[k]; i++)
      if (fr[k][i].held && c >= fr[k][i].acc + 1 && c <= fr[k][i].start) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void accept(int k, int a, logic [DW-1:0] d);
    frame_t f;
    int n, e;
    n = nfr[k];
    f.acc = a; f.data = d; f.held = 1'b0; f.start = a + 1;
    if (n > 0) begin
      e = fr[k][n-1].start + flen(k);
      if (a < e) begin
        f.held  = 1'b1;
        f.start = (a <= e - 2) ? e : e + 1;
      end
    end
    if (n < MAXF) begin
      fr[k][n] = f;
      nfr[k] = n + 1;
    end
  endfunction

  task automatic chk(input string tag, input int k, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s dut%0d cyc %0d observed %b expected %b", tag, k, cyc, obs, expv);
    end
  endtask

  task automatic check_all();
    logic e_tx, e_busy, e_done;
    int s, l;
    for (int k = 0; k < NDUT; k++) begin
      e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      l = flen(k);
      for (int i = 0; i < nfr[k]; i++) begin
        s = fr[k][i].start;
        if (cyc >= s && cyc < s + l) begin
          e_busy = 1'b1;
          e_tx   = line_at(k, fr[k][i].data, cyc - s);
        end
        if (cyc == s + l) e_done = 1'b1;
      end
      chk("tx", k, o_tx[k], e_tx);
      chk("tx_busy", k, o_busy[k], e_busy);
      chk("tx_done", k, o_done[k], e_done);
      chk("tx_ready", k, o_ready[k], exp_ready(k, cyc));
    end
  endtask

  // One clock: check outputs mid-cycle, drive inputs, update model at the edge.
  task automatic step(input logic en, input logic [DW-1:0] d, input logic r);
    @(negedge clk);
    if (chk_en) check_all();
    rst = r; tx_en = en; tx_data = d;
    if (!r && en)
      for (int k = 0; k < NDUT; k++)
        if (exp_ready(k, cyc)) accept(k, cyc, d);
    @(posedge clk);
    if (r) for (int k = 0; k < NDUT; k++) nfr[k] = 0;
    chk_en = 1'b1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0);
  endtask

  initial begin
    for (int k = 0; k < NDUT; k++) nfr[k] = 0;
    // reset, then idle checks
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    idle(3);
    // single frame 0xA5
    step(1'b1, 8'hA5, 1'b0); idle(120);
    // 0x01 then 0x80 five cycles later (parked, back-to-back)
    step(1'b1, 8'h01, 1'b0); idle(4); step(1'b1, 8'h80, 1'b0); idle(220);
    // parity pattern 0x07
    step(1'b1, 8'h07, 1'b0); idle(120);
    // second accept on the last stop cycle of each configuration
    step(1'b1, 8'h5A, 1'b0); idle(79); step(1'b1, 8'hC3, 1'b0); idle(250);
    step(1'b1, 8'h96, 1'b0); idle(87); step(1'b1, 8'h69, 1'b0); idle(250);
    step(1'b1, 8'hF0, 1'b0); idle(95); step(1'b1, 8'h0F, 1'b0); idle(250);
    // hold full: 0x3C must be ignored
    step(1'b1, 8'h11, 1'b0); idle(2); step(1'b1, 8'h22, 1'b0); idle(6);
    step(1'b1, 8'h3C, 1'b0); idle(250);
    // reset mid-frame, then a fresh frame
    step(1'b1, 8'hFF, 1'b0); idle(39); step(1'b0, 8'h00, 1'b1); idle(5);
    step(1'b1, 8'h00, 1'b0); idle(120);
    // random traffic with occasional resets
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(399) == 0) step(1'b0, 8'($urandom), 1'b1);
      else step(1'($urandom_range(11) == 0), 8'($urandom), 1'b0);
    end
    idle(120);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
